sprite_blitter: RTL
===================

// Module: sprite_blitter
// PURPOSE
//  Reader side of the sprite ROM interface. Walks a sprite ROM (pixel index in;
//  color, 0-indexed width/height out) row-major. Writes every opaque pixel into
//  the framebuffer at a signed screen position. Pixels outside the screen are
//  clipped, and the sprite can be mirrored horizontally. Sits between the game
//  FSM (start/x/y) and the framebuffer write port.
// PARAMETERS
//  FB_W   320       framebuffer width in pixels
//  FB_H   240       framebuffer height in pixels
//  TRANSP 16'hffff  color key treated as transparent; never written
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   synchronous reset, active low
//  start       in   1   begin a blit; sampled only in IDLE
//  pos_x       in   10  signed screen x of sprite column 0
//  pos_y       in   10  signed screen y of sprite row 0
//  flip_h      in   1   1 = mirror horizontally (left sprite drawn facing right)
//  busy        out  1   high from the cycle after start is accepted until done
//  done        out  1   one-cycle pulse when the blit completes
//  spr_pixel   out  17  pixel index to the sprite ROM
//  spr_color   in   16  RGB565 color from the ROM; combinational, same cycle
//  spr_width   in   9   sprite width-1, from the ROM
//  spr_height  in   9   sprite height-1, from the ROM
//  fb_we       out  1   framebuffer write request
//  fb_addr     out  17  framebuffer address = sy*FB_W + sx
//  fb_data     out  16  framebuffer pixel color
//  fb_ready    in   1   framebuffer accepts when fb_we && fb_ready
// BEHAVIOUR
//  Reset values
//   - State IDLE. busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, spr_pixel=0.
//   - rst_n low mid-blit aborts the blit on that edge. No done pulse is issued.
//  States
//   - IDLE -> RUN when start=1. In the same edge, latch pos_x, pos_y, flip_h,
//     spr_width (W) and spr_height (H), and clear row and col to 0.
//   - RUN -> FLUSH after the pixel at (row=H, col=W) is issued.
//   - FLUSH -> DONE once the stage-1 register is empty, meaning fb_we=0 or the
//     write was accepted.
//   - DONE -> IDLE after one cycle. done=1 in DONE only.
//   - start is ignored while busy.
//  Stage 0 (RUN)
//   - spr_pixel = rowbase + ccol.
//   - ccol = flip ? W-col : col.
//   - rowbase is an accumulator that adds W+1 per row. No multiplier is used.
//  Stage 1
//   - Register fb_we, fb_addr and fb_data from stage 0.
//   - sx = pos_x + col, sy = pos_y + row, both 11-bit signed.
//   - fb_we=1 only if spr_color != TRANSP, 0 <= sx < FB_W and 0 <= sy < FB_H.
//   - Skipped pixels (transparent or clipped) cost one cycle each and produce
//     no write.
//  Stall
//   - While fb_we=1 and fb_ready=0, the counters, spr_pixel and the stage-1
//     register all hold.
//   - fb_addr and fb_data stay stable until the write is accepted.
//  Throughput and latency
//   - One pixel per cycle when fb_ready=1.
//   - Earliest first fb_we is 2 cycles after the start edge.
//   - An unstalled blit takes (W+1)(H+1) + 3 cycles from start to the done
//     pulse.
//  Counter wrap
//   - col wraps W->0 and row increments.
//   - W=0 and H=0 is legal: one pixel is issued.
//  Widths
//   - fb_addr is computed in 17 bits. The maximum is FB_W*FB_H-1 = 76799, so it
//     cannot overflow.
// TESTING
//  1. 4x2 opaque ROM (W=3,H=1), pos (10,5), fb_ready=1 -> 8 writes at addr
//     1610..1613 and 1930..1933; done 11 cycles after start.
//  2. Same ROM with pixel 2 = 16'hffff -> 7 writes; addr 1612 is never written;
//     cycle count is unchanged.
//  3. flip_h=1, ROM row0 = A,B,C,D -> addr 1610 gets D and 1613 gets A.
//  4. pos (-2,-1), 4x2 -> only row1 cols 2,3 are written: addr 0 and 1.
//     pos (318,239) -> only addr 76798 and 76799 are written.
//  5. fb_ready low for 3 cycles on the 2nd write -> fb_addr and fb_data held;
//     no pixel lost or duplicated; done is delayed by exactly 3 cycles.
//  6. rst_n low for 1 cycle mid-blit -> next cycle busy=0, fb_we=0, no done
//     pulse; a new start then blits normally.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite ROM reader that walks the sprite row-major and pushes opaque, on-screen
// pixels into the framebuffer write port through a two-register pipeline.
module sprite_blitter #(
  parameter int          FB_W   = 320,
  parameter int          FB_H   = 240,
  parameter logic [15:0] TRANSP = 16'hffff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        flip_h,
  output logic        busy,
  output logic        done,
  output logic [16:0] spr_pixel,
  input  logic [15:0] spr_color,
  input  logic [8:0]  spr_width,
  input  logic [8:0]  spr_height,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [15:0] fb_data,
  input  logic        fb_ready
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state;
  logic [8:0]         w_q, h_q, row, col;
  logic [16:0]        rowbase;
  logic signed [10:0] px_q, py_q, s0_sx, s0_sy;
  logic               flip_q, s0_v;

  // Handshake: a write transfers on any rising edge where fb_we && fb_ready;
  // while fb_we is high and fb_ready low the whole pipeline freezes.
  logic        stall;
  logic [8:0]  ccol;
  logic        in_fb;
  logic [16:0] addr_n;

  always_comb begin
    stall  = fb_we && !fb_ready;
    ccol   = flip_q ? (w_q - col) : col;
    in_fb  = !s0_sx[10] && (s0_sx[9:0] < 10'(FB_W)) &&
             !s0_sy[10] && (s0_sy[9:0] < 10'(FB_H));
    addr_n = 17'(s0_sy[8:0]) * 17'(FB_W) + 17'(s0_sx[8:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      spr_pixel <= '0;
      w_q       <= '0;
      h_q       <= '0;
      row       <= '0;
      col       <= '0;
      rowbase   <= '0;
      px_q      <= '0;
      py_q      <= '0;
      s0_sx     <= '0;
      s0_sy     <= '0;
      flip_q    <= 1'b0;
      s0_v      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Stage 1: spr_color belongs to the registered spr_pixel of stage 0.
      if (!stall) begin
        fb_we   <= s0_v && (spr_color != TRANSP) && in_fb;
        fb_addr <= addr_n;
        fb_data <= spr_color;
        s0_v    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            px_q    <= $signed({pos_x[9], pos_x});
            py_q    <= $signed({pos_y[9], pos_y});
            flip_q  <= flip_h;
            w_q     <= spr_width;
            h_q     <= spr_height;
            row     <= '0;
            col     <= '0;
            rowbase <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            s0_v      <= 1'b1;
            spr_pixel <= rowbase + 17'(ccol);
            s0_sx     <= px_q + $signed({2'b00, col});
            s0_sy     <= py_q + $signed({2'b00, row});
            if (col == w_q) begin
              col     <= '0;
              row     <= row + 9'd1;
              rowbase <= rowbase + 17'(w_q) + 17'd1;
              if (row == h_q) state <= FLUSH;
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        FLUSH: begin
          if (!s0_v && (!fb_we || fb_ready)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
